// File: rtl/lmho_fifo_flex_pkg.sv
// lmho_fifo_pkg
// Shared definitions for the flexible FIFO:
//   fifo_mode_e  read-mode selector (standard registered read or first-word-fall-through)
//   cnt_width()  bits needed to hold an occupancy of 0..words
//   ptr_width()  bits needed to address 0..words-1
//   ptr_inc()    pointer advance with explicit wrap, so any depth works (not only powers of two)
package lmho_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned cnt_width(input int unsigned words);
    return $clog2(words + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned words);
    return (words > 2) ? $clog2(words) : 1;
  endfunction

  // Width of the occupancy count for the default depth of 4 words.
  localparam int unsigned DEFAULT_CNT_W = 3;

  // Wrap at words-1 back to 0 by comparison, never by truncating the pointer.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned words);
    return (ptr >= words - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/lmho_fifo_flex_ram.sv
// lmho_fifo_ram
// WORDS x WIDTH storage with one synchronous write port and one asynchronous
// read port. Contents are never reset.
//   clk      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational from i_raddr)
module lmho_fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORDS = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lmho_fifo_flex.sv
// lmho_fifo_flex
// Parametrised synchronous FIFO of any depth >= 2 with selectable read mode.
// All status outputs are registered from the next-state occupancy.
//   clk            clock
//   reset          synchronous active-high reset
//   flush          synchronous clear of pointers, count, flags and sticky errors
//   winc/wdata     write request and data
//   wfull          full, writes ignored
//   walmost_full   count >= AF_THRESH
//   rinc           read request (FWFT: pop of head word)
//   rdata/rvalid   read data and its qualifier
//   rempty         empty, reads ignored
//   ralmost_empty  count <= AE_THRESH
//   count          occupancy
//   overflow       sticky: winc while full
//   underflow      sticky: rinc while empty
module lmho_fifo_flex
  import lmho_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned WORDS     = 4,
  parameter int unsigned MODE      = 0,
  parameter int unsigned AF_THRESH = 3,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          winc,
  input  logic [WIDTH-1:0]              wdata,
  output logic                          wfull,
  output logic                          walmost_full,
  input  logic                          rinc,
  output logic [WIDTH-1:0]              rdata,
  output logic                          rempty,
  output logic                          ralmost_empty,
  output logic                          rvalid,
  output logic [$clog2(WORDS+1)-1:0]    count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned CW = cnt_width(WORDS);
  localparam int unsigned PW = ptr_width(WORDS);

  localparam logic [CW-1:0] L_WORDS = CW'(WORDS);
  localparam logic [CW-1:0] L_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] L_AE    = CW'(AE_THRESH);

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_wfull;
  logic             r_rempty;
  logic             r_walmost_full;
  logic             r_ralmost_empty;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_en;
  logic             w_rd_en;
  logic [CW-1:0]    w_count_next;
  logic [WIDTH-1:0] w_ram_rdata;

  // Flush blocks both ports for the cycle it is asserted.
  assign w_wr_en = winc & ~r_wfull  & ~flush;
  assign w_rd_en = rinc & ~r_rempty & ~flush;

  assign w_count_next = r_count + CW'(w_wr_en) - CW'(w_rd_en);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_wfull         <= 1'b0;
      r_rempty        <= 1'b1;
      r_walmost_full  <= 1'b0;
      r_ralmost_empty <= 1'b1;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= PW'(ptr_inc(32'(r_wptr), WORDS));
      end
      if (w_rd_en) begin
        r_rptr <= PW'(ptr_inc(32'(r_rptr), WORDS));
      end
      r_count         <= w_count_next;
      r_wfull         <= (w_count_next == L_WORDS);
      r_rempty        <= (w_count_next == '0);
      r_walmost_full  <= (w_count_next >= L_AF);
      r_ralmost_empty <= (w_count_next <= L_AE);
      r_overflow      <= r_overflow  | (winc & r_wfull);
      r_underflow     <= r_underflow | (rinc & r_rempty);
    end
  end

  lmho_fifo_ram #(
    .WIDTH (WIDTH),
    .WORDS (WORDS),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wptr),
    .i_wdata (wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_rdata)
  );

  generate
    if (MODE == 32'(FIFO_FWFT)) begin : g_fwft
      // Head word is always presented; a read just advances to the next one.
      assign rdata  = w_ram_rdata;
      assign rvalid = ~r_rempty;
    end else begin : g_std
      logic [WIDTH-1:0] r_rdata;
      logic             r_rvalid;

      // Output register kept here (not in the RAM) so a BRAM-based store can absorb it.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else if (flush) begin
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_rd_en;
          if (w_rd_en) begin
            r_rdata <= w_ram_rdata;
          end
        end
      end

      assign rdata  = r_rdata;
      assign rvalid = r_rvalid;
    end
  endgenerate

  assign wfull         = r_wfull;
  assign rempty        = r_rempty;
  assign walmost_full  = r_walmost_full;
  assign ralmost_empty = r_ralmost_empty;
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule
